// File: rtl/stroke_sequencer_pkg.sv
// ============================================================================
// Module   : stroke_sequencer_pkg
// Purpose  : Shared types, constants and segment builders for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stroke_sequencer_pkg;

    localparam int DEF_COORD_W = 8;

    localparam int GLYPH_ZERO  = 0;
    localparam int GLYPH_ONE   = 1;
    localparam int GLYPH_TWO   = 2;
    localparam int GLYPH_THREE = 3;
    localparam int GLYPH_FOUR  = 4;
    localparam int GLYPH_FIVE  = 5;
    localparam int GLYPH_SIX   = 6;
    localparam int GLYPH_SEVEN = 7;
    localparam int GLYPH_EIGHT = 8;
    localparam int GLYPH_NINE  = 9;

    localparam logic PEN_UP = 1'b0;
    localparam logic PEN_DN = 1'b1;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] sx;
        logic [DEF_COORD_W-1:0] sy;
        logic [DEF_COORD_W-1:0] ex;
        logic [DEF_COORD_W-1:0] ey;
        logic                   pen_down;
        logic                   last;
    } seg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic seg_t mk_seg(input int sx, input int sy, input int ex, input int ey,
                                    input logic pd);
        seg_t s;
        s.sx       = DEF_COORD_W'(sx);
        s.sy       = DEF_COORD_W'(sy);
        s.ex       = DEF_COORD_W'(ex);
        s.ey       = DEF_COORD_W'(ey);
        s.pen_down = pd;
        s.last     = 1'b0;
        return s;
    endfunction

    // Closing travel move back to the glyph origin.
    function automatic seg_t mk_end(input int sx, input int sy);
        seg_t s;
        s      = mk_seg(sx, sy, 0, 0, PEN_UP);
        s.last = 1'b1;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stroke_rom.sv
// ============================================================================
// Module   : stroke_rom
// Purpose  : Combinational stroke table for digits 0-9, indexed by segment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stroke_rom
    import stroke_sequencer_pkg::*;
#(
    parameter int GLYPH_W   = 4,
    parameter int SEG_IDX_W = 5
) (
    input  logic [GLYPH_W-1:0]   glyph_i,
    input  logic [SEG_IDX_W-1:0] idx_i,
    output seg_t                 seg_o
);

    // Unlisted (glyph, idx) pairs yield a null segment marked last.
    always_comb begin
        seg_o      = '0;
        seg_o.last = 1'b1;
        case (int'(glyph_i))
            GLYPH_ZERO: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0,  60,  40, PEN_UP);
                1: seg_o = mk_seg( 60,  40, 180,  40, PEN_DN);
                2: seg_o = mk_seg(180,  40, 180, 120, PEN_DN);
                3: seg_o = mk_seg(180, 120,  60, 120, PEN_DN);
                4: seg_o = mk_seg( 60, 120,  60,  40, PEN_DN);
                5: seg_o = mk_end( 60,  40);
                default: ;
            endcase
            GLYPH_ONE: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0, 120,  40, PEN_UP);
                1: seg_o = mk_seg(120,  40, 120, 120, PEN_DN);
                2: seg_o = mk_end(120, 120);
                default: ;
            endcase
            GLYPH_TWO: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0,  60,  40, PEN_UP);
                1: seg_o = mk_seg( 60,  40, 180,  40, PEN_DN);
                2: seg_o = mk_seg(180,  40, 120, 120, PEN_DN);
                3: seg_o = mk_seg(120, 120,  60, 120, PEN_DN);
                4: seg_o = mk_seg( 60, 120, 180, 120, PEN_DN);
                5: seg_o = mk_end(180, 120);
                default: ;
            endcase
            GLYPH_THREE: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0,  60,  40, PEN_UP);
                1: seg_o = mk_seg( 60,  40, 180,  40, PEN_DN);
                2: seg_o = mk_seg(180,  40, 180, 120, PEN_DN);
                3: seg_o = mk_seg(180, 120,  60, 120, PEN_DN);
                4: seg_o = mk_seg( 60, 120, 120,  80, PEN_UP);
                5: seg_o = mk_seg(120,  80, 180,  80, PEN_DN);
                6: seg_o = mk_end(180,  80);
                default: ;
            endcase
            GLYPH_FOUR: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0,  60,  40, PEN_UP);
                1: seg_o = mk_seg( 60,  40,  60,  80, PEN_DN);
                2: seg_o = mk_seg( 60,  80, 180,  80, PEN_DN);
                3: seg_o = mk_seg(180,  80, 180,  40, PEN_UP);
                4: seg_o = mk_seg(180,  40, 180, 120, PEN_DN);
                5: seg_o = mk_end(180, 120);
                default: ;
            endcase
            GLYPH_FIVE: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0, 180,  40, PEN_UP);
                1: seg_o = mk_seg(180,  40,  60,  40, PEN_DN);
                2: seg_o = mk_seg( 60,  40,  60,  80, PEN_DN);
                3: seg_o = mk_seg( 60,  80, 180,  80, PEN_DN);
                4: seg_o = mk_seg(180,  80, 180, 120, PEN_DN);
                5: seg_o = mk_seg(180, 120,  60, 120, PEN_DN);
                6: seg_o = mk_end( 60, 120);
                default: ;
            endcase
            GLYPH_SIX: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0, 180,  40, PEN_UP);
                1: seg_o = mk_seg(180,  40,  60,  40, PEN_DN);
                2: seg_o = mk_seg( 60,  40,  60, 120, PEN_DN);
                3: seg_o = mk_seg( 60, 120, 180, 120, PEN_DN);
                4: seg_o = mk_seg(180, 120, 180,  80, PEN_DN);
                5: seg_o = mk_seg(180,  80,  60,  80, PEN_DN);
                6: seg_o = mk_end( 60,  80);
                default: ;
            endcase
            GLYPH_SEVEN: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0,  60,  40, PEN_UP);
                1: seg_o = mk_seg( 60,  40, 180,  40, PEN_DN);
                2: seg_o = mk_seg(180,  40,  60, 120, PEN_DN);
                3: seg_o = mk_end( 60, 120);
                default: ;
            endcase
            GLYPH_EIGHT: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0,  60,  40, PEN_UP);
                1: seg_o = mk_seg( 60,  40, 180,  40, PEN_DN);
                2: seg_o = mk_seg(180,  40, 180, 120, PEN_DN);
                3: seg_o = mk_seg(180, 120,  60, 120, PEN_DN);
                4: seg_o = mk_seg( 60, 120,  60,  40, PEN_DN);
                5: seg_o = mk_seg( 60,  40, 120,  40, PEN_UP);
                6: seg_o = mk_seg(120,  40, 120, 120, PEN_DN);
                7: seg_o = mk_end(120, 120);
                default: ;
            endcase
            GLYPH_NINE: case (int'(idx_i))
                0: seg_o = mk_seg(  0,   0, 180, 120, PEN_UP);
                1: seg_o = mk_seg(180, 120, 180,  40, PEN_DN);
                2: seg_o = mk_seg(180,  40,  60,  40, PEN_DN);
                3: seg_o = mk_seg( 60,  40,  60,  80, PEN_DN);
                4: seg_o = mk_seg( 60,  80, 180,  80, PEN_DN);
                5: seg_o = mk_end(180,  80);
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/stroke_sequencer.sv
// ============================================================================
// Module   : stroke_sequencer
// Purpose  : Walks a glyph's strokes, translates/clamps them, streams segments.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stroke_sequencer
    import stroke_sequencer_pkg::*;
#(
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SEG_IDX_W  = 5,
    parameter int NUM_GLYPHS = 10,
    parameter int GLYPH_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [GLYPH_W-1:0]   req_glyph_i,
    input  logic [COORD_W-1:0]   req_org_x_i,
    input  logic [COORD_W-1:0]   req_org_y_i,
    input  logic                 abort_i,
    output logic                 seg_valid_o,
    input  logic                 seg_ready_i,
    output logic [COORD_W-1:0]   seg_start_x_o,
    output logic [COORD_W-1:0]   seg_start_y_o,
    output logic [COORD_W-1:0]   seg_end_x_o,
    output logic [COORD_W-1:0]   seg_end_y_o,
    output logic                 seg_pen_down_o,
    output logic [SEG_IDX_W-1:0] seg_idx_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 clipped_o
);

    state_t               state_q, state_d;
    logic [GLYPH_W-1:0]   glyph_q, glyph_d;
    logic [COORD_W-1:0]   org_x_q, org_x_d;
    logic [COORD_W-1:0]   org_y_q, org_y_d;
    logic [SEG_IDX_W-1:0] idx_q, idx_d;
    logic [COORD_W-1:0]   coord_q [4];
    logic [COORD_W-1:0]   coord_d [4];
    logic                 pen_q, pen_d;
    logic                 last_q, last_d;
    logic                 clip_q, clip_d;
    logic                 err_q, err_d;

    seg_t                 w_rom;
    logic [COORD_W-1:0]   w_rom_c [4];
    logic [COORD_W-1:0]   w_org   [4];
    logic [COORD_W-1:0]   w_clamp [4];
    logic [3:0]           w_over;
    logic                 w_glyph_bad;

    stroke_rom #(
        .GLYPH_W   (GLYPH_W),
        .SEG_IDX_W (SEG_IDX_W)
    ) u_rom (
        .glyph_i (glyph_q),
        .idx_i   (idx_q),
        .seg_o   (w_rom)
    );

    assign w_rom_c[0] = COORD_W'(w_rom.sx);
    assign w_rom_c[1] = COORD_W'(w_rom.sy);
    assign w_rom_c[2] = COORD_W'(w_rom.ex);
    assign w_rom_c[3] = COORD_W'(w_rom.ey);
    assign w_org[0]   = org_x_q;
    assign w_org[1]   = org_y_q;
    assign w_org[2]   = org_x_q;
    assign w_org[3]   = org_y_q;

    // One extra bit of headroom catches overflow, which saturates to full scale.
    always_comb begin
        logic [COORD_W:0] sum;
        w_over = '0;
        for (int i = 0; i < 4; i++) begin
            sum        = {1'b0, w_rom_c[i]} + {1'b0, w_org[i]};
            w_over[i]  = sum[COORD_W];
            w_clamp[i] = sum[COORD_W] ? '1 : sum[COORD_W-1:0];
        end
    end

    assign w_glyph_bad = (int'(req_glyph_i) >= NUM_GLYPHS);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            glyph_q <= '0;
            org_x_q <= '0;
            org_y_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < 4; i++) coord_q[i] <= '0;
            pen_q   <= 1'b0;
            last_q  <= 1'b0;
            clip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            glyph_q <= glyph_d;
            org_x_q <= org_x_d;
            org_y_q <= org_y_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 4; i++) coord_q[i] <= coord_d[i];
            pen_q   <= pen_d;
            last_q  <= last_d;
            clip_q  <= clip_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        glyph_d = glyph_q;
        org_x_d = org_x_q;
        org_y_d = org_y_q;
        idx_d   = idx_q;
        coord_d = coord_q;
        pen_d   = pen_q;
        last_d  = last_q;
        clip_d  = clip_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    glyph_d = req_glyph_i;
                    org_x_d = req_org_x_i;
                    org_y_d = req_org_y_i;
                    idx_d   = '0;
                    clip_d  = 1'b0;
                    err_d   = w_glyph_bad;
                    state_d = w_glyph_bad ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                coord_d = w_clamp;
                pen_d   = w_rom.pen_down;
                last_d  = w_rom.last;
                clip_d  = clip_q | (|w_over);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (seg_ready_i) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (&idx_q) begin
                        // Table ran off the index range without a terminator.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign seg_valid_o    = (state_q == ST_SEND);
    assign done_o         = (state_q == ST_DONE) && !abort_i;
    assign err_o          = done_o && err_q;
    assign clipped_o      = done_o && clip_q;
    assign seg_start_x_o  = coord_q[0];
    assign seg_start_y_o  = coord_q[1];
    assign seg_end_x_o    = coord_q[2];
    assign seg_end_y_o    = coord_q[3];
    assign seg_pen_down_o = pen_q;
    assign seg_idx_o      = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_stroke_sequencer.sv
// ============================================================================
// Module   : tb_stroke_sequencer
// Purpose  : Randomised self-checking bench against a path-based glyph model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stroke_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [3:0] req_glyph_i;
    logic [7:0] req_org_x_i;
    logic [7:0] req_org_y_i;
    logic       abort_i;
    logic       seg_valid_o;
    logic       seg_ready_i;
    logic [7:0] seg_start_x_o;
    logic [7:0] seg_start_y_o;
    logic [7:0] seg_end_x_o;
    logic [7:0] seg_end_y_o;
    logic       seg_pen_down_o;
    logic [4:0] seg_idx_o;
    logic       done_o;
    logic       err_o;
    logic       clipped_o;

    stroke_sequencer u_dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_glyph_i    (req_glyph_i),
        .req_org_x_i    (req_org_x_i),
        .req_org_y_i    (req_org_y_i),
        .abort_i        (abort_i),
        .seg_valid_o    (seg_valid_o),
        .seg_ready_i    (seg_ready_i),
        .seg_start_x_o  (seg_start_x_o),
        .seg_start_y_o  (seg_start_y_o),
        .seg_end_x_o    (seg_end_x_o),
        .seg_end_y_o    (seg_end_y_o),
        .seg_pen_down_o (seg_pen_down_o),
        .seg_idx_o      (seg_idx_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .clipped_o      (clipped_o)
    );

    always #5 clk_i = ~clk_i;

    // Glyphs are described as pen paths: each point is reached from the
    // previous one (starting at the origin) with the given pen state.
    typedef struct { int g; int x; int y; bit pd; } pt_t;
    typedef struct { int sx; int sy; int ex; int ey; bit pd; bit last; } eseg_t;

    pt_t   pts[$];
    eseg_t exp_q[$];
    bit    exp_clip;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add_pt(input int g, input int x, input int y, input bit pd);
        pt_t p;
        p.g = g; p.x = x; p.y = y; p.pd = pd;
        pts.push_back(p);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic build_expected(input int g, input int ox, input int oy);
        int px = 0;
        int py = 0;
        int n  = 0;
        int k  = 0;
        exp_q    = {};
        exp_clip = 1'b0;
        foreach (pts[i]) if (pts[i].g == g) n++;
        foreach (pts[i]) begin
            if (pts[i].g == g) begin
                eseg_t e;
                e.sx = sat(px + ox); e.sy = sat(py + oy);
                e.ex = sat(pts[i].x + ox); e.ey = sat(pts[i].y + oy);
                e.pd = pts[i].pd;
                k++;
                e.last = (k == n);
                if (px + ox > 255 || py + oy > 255 || pts[i].x + ox > 255 || pts[i].y + oy > 255)
                    exp_clip = 1'b1;
                exp_q.push_back(e);
                px = pts[i].x; py = pts[i].y;
            end
        end
    endtask

    task automatic check_seg(input string tag, input eseg_t e, input int k);
        check_value({tag, "_valid"}, int'(seg_valid_o), 1);
        check_value({tag, "_sx"}, int'(seg_start_x_o), e.sx);
        check_value({tag, "_sy"}, int'(seg_start_y_o), e.sy);
        check_value({tag, "_ex"}, int'(seg_end_x_o), e.ex);
        check_value({tag, "_ey"}, int'(seg_end_y_o), e.ey);
        check_value({tag, "_pen"}, int'(seg_pen_down_o), int'(e.pd));
        check_value({tag, "_idx"}, int'(seg_idx_o), k);
        check_value({tag, "_done"}, int'(done_o), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic run_glyph(input int g, input int ox, input int oy,
                             input int stall_pct, input int abort_at);
        string tag;
        build_expected(g, ox, oy);
        check_value($sformatf("g%0d_ready_pre", g), int'(req_ready_o), 1);
        req_valid_i = 1'b1;
        req_glyph_i = 4'(g);
        req_org_x_i = 8'(ox);
        req_org_y_i = 8'(oy);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_glyph_i = 4'($urandom);
        req_org_x_i = 8'($urandom);
        req_org_y_i = 8'($urandom);
        check_value($sformatf("g%0d_accept_valid", g), int'(seg_valid_o), 0);
        if (exp_q.size() == 0) begin
            check_value($sformatf("g%0d_bad_done", g), int'(done_o), 1);
            check_value($sformatf("g%0d_bad_err", g), int'(err_o), 1);
            check_value($sformatf("g%0d_bad_clip", g), int'(clipped_o), 0);
            @(negedge clk_i);
            check_value($sformatf("g%0d_bad_ready", g), int'(req_ready_o), 1);
            check_value($sformatf("g%0d_bad_done_end", g), int'(done_o), 0);
            check_value($sformatf("g%0d_bad_seg_valid", g), int'(seg_valid_o), 0);
            return;
        end
        check_value($sformatf("g%0d_load_done", g), int'(done_o), 0);
        check_value($sformatf("g%0d_load_ready", g), int'(req_ready_o), 0);
        foreach (exp_q[k]) begin
            int stalls = 0;
            @(negedge clk_i);
            tag = $sformatf("g%0d_s%0d", g, k);
            check_seg(tag, exp_q[k], k);
            if (k == abort_at) begin
                abort_i     = 1'b1;
                seg_ready_i = 1'($urandom_range(0, 1));
                @(negedge clk_i);
                abort_i     = 1'b0;
                seg_ready_i = 1'b0;
                check_value({tag, "_abort_valid"}, int'(seg_valid_o), 0);
                check_value({tag, "_abort_done"}, int'(done_o), 0);
                check_value({tag, "_abort_ready"}, int'(req_ready_o), 1);
                return;
            end
            while (int'($urandom_range(0, 99)) < stall_pct && stalls < 6) begin
                seg_ready_i = 1'b0;
                @(negedge clk_i);
                check_seg({tag, "_hold"}, exp_q[k], k);
                stalls++;
            end
            seg_ready_i = 1'b1;
            @(negedge clk_i);
            seg_ready_i = 1'b0;
            check_value({tag, "_bubble_valid"}, int'(seg_valid_o), 0);
            if (exp_q[k].last) begin
                check_value({tag, "_done"}, int'(done_o), 1);
                check_value({tag, "_err"}, int'(err_o), 0);
                check_value({tag, "_clipped"}, int'(clipped_o), int'(exp_clip));
                check_value({tag, "_ready_in_done"}, int'(req_ready_o), 0);
                @(negedge clk_i);
                check_value({tag, "_ready_after"}, int'(req_ready_o), 1);
                check_value({tag, "_done_after"}, int'(done_o), 0);
            end else begin
                check_value({tag, "_early_done"}, int'(done_o), 0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_ready"}, int'(req_ready_o), 1);
        check_value({tag, "_valid"}, int'(seg_valid_o), 0);
        check_value({tag, "_done"}, int'(done_o), 0);
        check_value({tag, "_err"}, int'(err_o), 0);
        check_value({tag, "_clip"}, int'(clipped_o), 0);
        check_value({tag, "_pen"}, int'(seg_pen_down_o), 0);
        check_value({tag, "_coords"},
                    int'({seg_start_x_o, seg_start_y_o, seg_end_x_o, seg_end_y_o}), 0);
        check_value({tag, "_idx"}, int'(seg_idx_o), 0);
    endtask

    initial begin
        // Digit paths: rectangle corners A(60,40) B(180,40) C(180,120) D(60,120).
        add_pt(0, 60, 40, 0);  add_pt(0, 180, 40, 1); add_pt(0, 180, 120, 1);
        add_pt(0, 60, 120, 1); add_pt(0, 60, 40, 1);  add_pt(0, 0, 0, 0);
        add_pt(1, 120, 40, 0); add_pt(1, 120, 120, 1); add_pt(1, 0, 0, 0);
        add_pt(2, 60, 40, 0);  add_pt(2, 180, 40, 1); add_pt(2, 120, 120, 1);
        add_pt(2, 60, 120, 1); add_pt(2, 180, 120, 1); add_pt(2, 0, 0, 0);
        add_pt(3, 60, 40, 0);  add_pt(3, 180, 40, 1); add_pt(3, 180, 120, 1);
        add_pt(3, 60, 120, 1); add_pt(3, 120, 80, 0); add_pt(3, 180, 80, 1);
        add_pt(3, 0, 0, 0);
        add_pt(4, 60, 40, 0);  add_pt(4, 60, 80, 1);  add_pt(4, 180, 80, 1);
        add_pt(4, 180, 40, 0); add_pt(4, 180, 120, 1); add_pt(4, 0, 0, 0);
        add_pt(5, 180, 40, 0); add_pt(5, 60, 40, 1);  add_pt(5, 60, 80, 1);
        add_pt(5, 180, 80, 1); add_pt(5, 180, 120, 1); add_pt(5, 60, 120, 1);
        add_pt(5, 0, 0, 0);
        add_pt(6, 180, 40, 0); add_pt(6, 60, 40, 1);  add_pt(6, 60, 120, 1);
        add_pt(6, 180, 120, 1); add_pt(6, 180, 80, 1); add_pt(6, 60, 80, 1);
        add_pt(6, 0, 0, 0);
        add_pt(7, 60, 40, 0);  add_pt(7, 180, 40, 1); add_pt(7, 60, 120, 1);
        add_pt(7, 0, 0, 0);
        add_pt(8, 60, 40, 0);  add_pt(8, 180, 40, 1); add_pt(8, 180, 120, 1);
        add_pt(8, 60, 120, 1); add_pt(8, 60, 40, 1);  add_pt(8, 120, 40, 0);
        add_pt(8, 120, 120, 1); add_pt(8, 0, 0, 0);
        add_pt(9, 180, 120, 0); add_pt(9, 180, 40, 1); add_pt(9, 60, 40, 1);
        add_pt(9, 60, 80, 1);  add_pt(9, 180, 80, 1); add_pt(9, 0, 0, 0);

        rst_n_i     = 1'b0;
        req_valid_i = 1'b0;
        req_glyph_i = '0;
        req_org_x_i = '0;
        req_org_y_i = '0;
        abort_i     = 1'b0;
        seg_ready_i = 1'b0;
        #3;
        check_reset_values("por");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Abort while idle must be ignored.
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check_value("idle_abort_ready", int'(req_ready_o), 1);

        run_glyph(8, 0, 0, 0, -1);
        run_glyph(8, 100, 10, 0, -1);
        run_glyph(12, 5, 5, 0, -1);
        run_glyph(8, 30, 60, 50, -1);
        run_glyph(8, 0, 0, 0, 3);
        run_glyph(1, 20, 20, 0, -1);

        // Asynchronous reset in the middle of a segment transfer.
        req_valid_i = 1'b1;
        req_glyph_i = 4'd8;
        req_org_x_i = 8'd200;
        req_org_y_i = 8'd200;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check_value("rst_pre_valid", int'(seg_valid_o), 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_reset_values("midjob_rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_value("rst_release_ready", int'(req_ready_o), 1);
        check_value("rst_release_done", int'(done_o), 0);

        for (int j = 0; j < 40; j++) begin
            int g  = int'($urandom_range(0, 15));
            int ox = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 70))
                                                 : int'($urandom_range(0, 255));
            int oy = int'($urandom_range(0, 255));
            int ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_glyph(g, ox, oy, int'($urandom_range(0, 70)), ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stroke_sequencer.md
# stroke_sequencer

Parametrised glyph stroke sequencer for the pen-plotter datapath. Accepts a glyph request (digit id plus placement origin), walks that glyph's segment list from an internal stroke ROM covering all digits 0-9, translates every coordinate by the origin with clamping, and streams segments to the line-drawing engine over a valid/ready handshake. Sits between the top-level drawing controller and the line drawer, replacing the per-digit combinational segment tables.

## Interface
- COORD_W, 8, coordinate width in bits
- SEG_IDX_W, 5, segment index width; max segments per glyph = 2^SEG_IDX_W
- NUM_GLYPHS, 10, number of glyphs in the ROM (ids 0..NUM_GLYPHS-1)
- GLYPH_W, 4, glyph id width

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  glyph request present
- req_ready  out  1  sequencer can accept a request
- req_glyph  in  GLYPH_W  glyph id
- req_org_x, req_org_y  in  COORD_W each  placement origin
- abort  in  1  cancel current job
- seg_valid  out  1  segment on seg_* is valid
- seg_ready  in  1  line drawer accepts segment
- seg_start_x, seg_start_y, seg_end_x, seg_end_y  out  COORD_W each  translated coordinates
- seg_pen_down  out  1  1 = draw, 0 = travel
- seg_idx  out  SEG_IDX_W  index of current segment within glyph
- done  out  1  one-cycle pulse, job finished normally
- err  out  1  one-cycle pulse with done, glyph id invalid
- clipped  out  1  valid with done, any coordinate clamped during the job

## Operation
- ROM entry: start_x, start_y, end_x, end_y, pen_down, last. Every glyph ends with a pen-up segment to (0,0) flagged last.
- Digit 8 entries 0..7: (0,0)->(60,40) up; (60,40)->(180,40) dn; (180,40)->(180,120) dn; (180,120)->(60,120) dn; (60,120)->(60,40) dn; (60,40)->(120,40) up; (120,40)->(120,120) dn; (120,120)->(0,0) up, last.
- Translation: each coordinate = ROM value + origin computed at COORD_W+1 bits; if result > 2^COORD_W-1, output 2^COORD_W-1 and set the clip flag for the job. Clip flag clears on request acceptance.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: req_ready=1. On req_valid: latch glyph and origin, idx=0. Valid glyph -> LOAD; glyph >= NUM_GLYPHS -> DONE with err.
  - LOAD: read ROM at (glyph, idx), register translated segment -> SEND.
  - SEND: seg_valid=1, outputs stable until seg_ready. On handshake: last=1 -> DONE; else idx+1 -> LOAD. If idx would wrap past 2^SEG_IDX_W-1 without last, go DONE with err.
  - DONE: done=1 (err, clipped as applicable) for one cycle -> IDLE.
- abort in any non-IDLE state: next state IDLE, seg_valid dropped, no done pulse. Abort in IDLE ignored. Abort and seg_ready in the same SEND cycle: abort wins, segment counted as not delivered.

## Timing
- Reset: state IDLE; req_ready=1; seg_valid, done, err, clipped, seg_pen_down=0; all coordinate outputs and seg_idx=0.
- Request accepted at cycle T -> first seg_valid at T+2.
- Segment handshake at S -> next seg_valid at S+2 (one LOAD bubble).
- Final handshake at S -> done at S+1, req_ready at S+2.
- Invalid glyph accepted at T -> done+err at T+1, no seg_valid.
- seg_valid never deasserts without handshake except on abort or reset.
- Reset mid-job: immediate return to reset values, no done.

## Structure
- Shared package: COORD_W default, segment record typedef (coords, pen_down, last), FSM state enum, glyph id constants.
- Sub-module stroke_rom: combinational lookup (glyph, idx) -> segment record; unused indices return zero record with last=1.
- Translation/clamp and FSM in stroke_sequencer.

## Test plan
- Glyph 8, origin (0,0), seg_ready=1 -> 8 segments matching table above, seg_idx 0..7, done at cycle after 8th handshake, clipped=0.
- Glyph 8, origin (100,10) -> second segment (160,50)->(255,50) clamped, clipped=1 with done.
- Glyph 12 -> no seg_valid, done=err=1 at T+1, req_ready again at T+2.
- Glyph 8, seg_ready toggled randomly -> segments held stable while stalled, same 8 segments in order.
- abort asserted during 4th SEND -> seg_valid low next cycle, no done, req_ready=1; new request for glyph 1 then completes normally.
- rst_n asserted during SEND -> all outputs at reset values asynchronously, req_ready=1 after release.
